// File: rtl/gen_loop_serializer.sv
// Parallel-to-serial transmitter: WIDTH-bit word in, one bit per beat out, optional even-parity beat (GEN_SER_PARITY_EN).
// Latency: first beat is valid the cycle after the word is accepted; one word per NBEATS+1 cycles at best.
// Backpressure: out_ready low freezes out_bit/out_last/beat count; in_ready is high only while idle.
`timescale 1ns/1ps
module gen_loop_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

`ifdef GEN_SER_PARITY_EN
    localparam int NBEATS = WIDTH + 1;
`else
    localparam int NBEATS = WIDTH;
`endif
    localparam int CW = $clog2(NBEATS + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic              state_q, state_d;
    logic [NBEATS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NBEATS-1:0] load_word;
    logic [NBEATS-1:0] shifted;
    logic              in_acc;
    logic              beat_acc;
    logic              last_beat;

    // The parity bit sits at the far end of the register so it leaves after the data bits.
`ifdef GEN_SER_PARITY_EN
    assign load_word = (MSB_FIRST != 0) ? {in_data, ^in_data} : {^in_data, in_data};
`else
    assign load_word = in_data;
`endif

    generate
        for (genvar i = 0; i < NBEATS; i++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (i == 0) begin : g_fill
                    assign shifted[i] = 1'b0;
                end else begin : g_move
                    assign shifted[i] = shreg_q[i-1];
                end
            end else begin : g_lsb
                if (i == NBEATS - 1) begin : g_fill
                    assign shifted[i] = 1'b0;
                end else begin : g_move
                    assign shifted[i] = shreg_q[i+1];
                end
            end
        end
    endgenerate

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT);
    assign in_acc    = in_valid && in_ready;
    assign beat_acc  = out_valid && out_ready;
    assign last_beat = (cnt_q == CW'(NBEATS - 1));
    assign out_last  = out_valid && last_beat;
    // Zero-fill guarantees the register is empty again once a frame drains, so out_bit is 0 when idle.
    assign out_bit   = (MSB_FIRST != 0) ? shreg_q[NBEATS-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (in_acc) begin
            state_d = ST_SHIFT;
            shreg_d = load_word;
            cnt_d   = '0;
        end else if (beat_acc) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
            if (last_beat) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_bit) && $stable(out_last)));

    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(NBEATS));

endmodule

// File: tb/tb_gen_loop_serializer.sv
// Bench for gen_loop_serializer: LSB-first and MSB-first instances share stimulus; a word/beat-index model checks every cycle.
`timescale 1ns/1ps
module tb_gen_loop_serializer;

    localparam int W = 8;
`ifdef GEN_SER_PARITY_EN
    localparam int NB  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic in_ready_l, out_bit_l, out_valid_l, out_last_l, busy_l;
    logic in_ready_m, out_bit_m, out_valid_m, out_last_m, busy_m;

    int n_pass = 0;
    int n_total = 0;

    bit           m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_beat = 0;

    logic [31:0] cap_l = '0;
    logic [31:0] cap_m = '0;
    int cap_n = 0;
    int last_at = -1;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    gen_loop_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_bit(out_bit_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l));

    gen_loop_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_bit(out_bit_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame bit number `beat` of word w: data bits in the chosen order, then the even-parity bit.
    function automatic logic exp_bit(input logic [W-1:0] w, input int beat, input bit msb);
        if (beat >= W) return ^w;
        if (msb) return w[W-1-beat];
        return w[beat];
    endfunction

    always @(negedge clk) begin
        logic exp_last, exp_bl, exp_bm;
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_beat = 0;
        end
        exp_last = m_busy && (m_beat == NB - 1);
        exp_bl   = m_busy ? exp_bit(m_word, m_beat, 1'b0) : 1'b0;
        exp_bm   = m_busy ? exp_bit(m_word, m_beat, 1'b1) : 1'b0;
        check("in_ready_l",  in_ready_l,  !m_busy);
        check("out_valid_l", out_valid_l, m_busy);
        check("busy_l",      busy_l,      m_busy);
        check("out_last_l",  out_last_l,  exp_last);
        check("out_bit_l",   out_bit_l,   exp_bl);
        check("in_ready_m",  in_ready_m,  !m_busy);
        check("out_valid_m", out_valid_m, m_busy);
        check("out_last_m",  out_last_m,  exp_last);
        check("out_bit_m",   out_bit_m,   exp_bm);

        if (rst_n && out_valid_l && out_ready) begin
            if (cap_n < 32) begin
                cap_l[cap_n] = out_bit_l;
                cap_m[cap_n] = out_bit_m;
            end
            if (out_last_l) last_at = cap_n;
            if (cap_n == 0) first_cyc = cyc;
            last_cyc = cyc;
            cap_n++;
        end

        if (rst_n) begin
            if (m_busy) begin
                if (out_ready) begin
                    m_beat++;
                    if (m_beat == NB) begin
                        m_busy = 1'b0;
                        m_beat = 0;
                    end
                end
            end else if (in_valid) begin
                m_busy = 1'b1;
                m_word = in_data;
                m_beat = 0;
            end
        end
    end

    task automatic clear_cap();
        cap_l = '0;
        cap_m = '0;
        cap_n = 0;
        last_at = -1;
    endtask

    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        for (int i = 0; i < 400 && cap_n < n; i++) @(posedge clk);
        check({name, "_beats"}, cap_n, n);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready_l,  1'b1);
        check("rst_out_valid", out_valid_l, 1'b0);
        check("rst_busy",      busy_l,      1'b0);
        check("rst_out_last",  out_last_l,  1'b0);
        check("rst_out_bit",   out_bit_m,   1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: A5 with constant ready
        out_ready = 1'b1;
        clear_cap();
        send(8'hA5);
        wait_beats(NB, "t1");
        check("t1_order", cap_l, 32'h0A5);
        check("t1_last",  last_at, NB - 1);
        check("t1_span",  last_cyc - first_cyc, NB - 1);
        check("t1_rdy",   in_ready_l, 1'b1);

        // 2: 3C with ready toggling
        clear_cap();
        send(8'h3C);
        for (int i = 0; i < 100 && cap_n < NB; i++) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("t2_beats", cap_n, NB);
        check("t2_order", cap_l, 32'h03C);
        check("t2_last",  last_at, NB - 1);

        // 3: 0F then FF held valid during the frame
        clear_cap();
        in_valid = 1'b1;
        in_data  = 8'h0F;
        @(posedge clk); #1;
        in_data = 8'hFF;
        for (int i = 0; i < 100 && cap_n < NB; i++) @(posedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_beats(2 * NB, "t3");
        check("t3_order", cap_l, PAR ? 32'h1FE0F : 32'h0FF0F);

        // 4: reset after three beats of AA, then 01
        clear_cap();
        send(8'hAA);
        wait_beats(3, "t4a");
        rst_n = 1'b0;
        #1;
        check("t4_valid_l", out_valid_l, 1'b0);
        check("t4_busy_l",  busy_l,      1'b0);
        check("t4_valid_m", out_valid_m, 1'b0);
        check("t4_ready",   in_ready_l,  1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_cap();
        send(8'h01);
        wait_beats(NB, "t4b");
        check("t4_order", cap_l, PAR ? 32'h101 : 32'h001);

        // 5: 80 on both bit orders
        clear_cap();
        send(8'h80);
        wait_beats(NB, "t5");
        check("t5_msb", cap_m, PAR ? 32'h101 : 32'h001);
        check("t5_lsb", cap_l, PAR ? 32'h180 : 32'h080);
        check("t5_last", last_at, NB - 1);

        // 6: 07 (odd weight, parity beat is 1 when enabled)
        clear_cap();
        send(8'h07);
        wait_beats(NB, "t6");
        check("t6_lsb", cap_l, PAR ? 32'h107 : 32'h007);
        check("t6_msb", cap_m, PAR ? 32'h1E0 : 32'h0E0);
        check("t6_last", last_at, NB - 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 499) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (NB + 4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
